// File: rtl/lfsr_sram_pkg.sv
// Shared types and LFSR helper for the LFSR-driven SRAM fill/check sweep.
package lfsr_sram_pkg;

    localparam int unsigned LFSR_MAX_W = 128;
    localparam logic [97:0] DEFAULT_TAP_MASK = 98'h2_0000_0000_0000_0000_0000_0041;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One Galois step; callers zero-extend narrower registers and mask.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] s,
                                                        input logic [LFSR_MAX_W-1:0] mask);
        return (s >> 1) ^ (s[0] ? mask : '0);
    endfunction

endpackage

// File: rtl/lfsr_sram_sweep_multistep.sv
// NUM_BANKS LFSR steps unrolled in one cycle; bank b receives step b+1.
module lfsr_multistep
    import lfsr_sram_pkg::*;
#(
    parameter int unsigned      REG_W     = 98,
    parameter int unsigned      DATA_W    = 64,
    parameter int unsigned      NUM_BANKS = 4,
    parameter logic [REG_W-1:0] TAP_MASK  = REG_W'(DEFAULT_TAP_MASK)
) (
    input  logic [REG_W-1:0]            state_in,
    output logic [NUM_BANKS*DATA_W-1:0] words,
    output logic [REG_W-1:0]            state_next
);

    always_comb begin
        logic [REG_W-1:0] s;
        s     = state_in;
        words = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            s = REG_W'(lfsr_step(LFSR_MAX_W'(s), LFSR_MAX_W'(TAP_MASK)));
            words[b*DATA_W +: DATA_W] = s[DATA_W-1:0];
        end
        state_next = s;
    end

endmodule

// File: rtl/lfsr_sram_sweep.sv
// Sweeps an address range over parallel SRAM banks, writing an LFSR pattern
// or regenerating it to count readback mismatches.
module lfsr_sram_sweep
    import lfsr_sram_pkg::*;
#(
    parameter int unsigned      REG_W     = 98,
    parameter int unsigned      DATA_W    = 64,
    parameter int unsigned      NUM_BANKS = 4,
    parameter int unsigned      ADDR_W    = 7,
    parameter logic [REG_W-1:0] TAP_MASK  = REG_W'(DEFAULT_TAP_MASK),
    parameter int unsigned      READ_LAT  = 1,
    parameter int unsigned      ERR_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REG_W-1:0]            rg_out,
    input  logic                        start,
    input  logic                        mode,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ADDR_W:0]             count,
    input  logic                        abort,
    input  logic [NUM_BANKS*DATA_W-1:0] dataout,
    output logic [NUM_BANKS*DATA_W-1:0] datain,
    output logic [ADDR_W-1:0]           address,
    output logic                        CSB,
    output logic                        WEB,
    output logic                        OEB,
    output logic                        busy,
    output logic                        done,
    output logic [ERR_W-1:0]            err_cnt,
    output logic [ADDR_W-1:0]           first_err_addr,
    output logic                        err_flag
);

    localparam int unsigned BUS_W = NUM_BANKS * DATA_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int unsigned MIS_W = $clog2(NUM_BANKS + 1);
    localparam int unsigned ACC_W = ERR_W + 1;

    state_t             state, state_next;
    logic [REG_W-1:0]   lfsr_q, seed, step_in, step_next;
    logic [BUS_W-1:0]   step_words;
    logic [CNT_W-1:0]   left_q;
    logic [LAT_W-1:0]   drain_q;
    logic [ADDR_W-1:0]  addr_next;
    logic               start_ok, abort_hit, cmp_en;
    logic               issue, rd_issue, csb_d, web_d, oeb_d, busy_d, done_d;
    logic [READ_LAT:0]  pipe_vld;
    logic [ADDR_W-1:0]  pipe_addr [READ_LAT+1];
    logic [BUS_W-1:0]   pipe_exp  [READ_LAT+1];
    logic [MIS_W-1:0]   mism;
    logic [ACC_W-1:0]   err_sum;
    logic [ERR_W-1:0]   err_next;

    assign start_ok  = (state == S_IDLE) && start;
    assign abort_hit = abort && ((state == S_WRITE) || (state == S_READ) || (state == S_DRAIN));
    assign seed      = (rg_out == '0) ? REG_W'(1) : rg_out;
    assign step_in   = (state == S_IDLE) ? seed : lfsr_q;
    assign addr_next = (state == S_IDLE) ? base_addr : address + ADDR_W'(1);

    lfsr_multistep #(
        .REG_W     (REG_W),
        .DATA_W    (DATA_W),
        .NUM_BANKS (NUM_BANKS),
        .TAP_MASK  (TAP_MASK)
    ) u_step (
        .state_in   (step_in),
        .words      (step_words),
        .state_next (step_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (count == '0) ? S_DONE : (mode ? S_READ : S_WRITE);
            S_WRITE: if (abort) state_next = S_IDLE;
                     else if (left_q == '0) state_next = S_DONE;
            S_READ:  if (abort) state_next = S_IDLE;
                     else if (left_q == '0) state_next = S_DRAIN;
            S_DRAIN: if (abort) state_next = S_IDLE;
                     else if (drain_q == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are computed from the next state so they register in step with it.
    always_comb begin
        issue    = 1'b0;
        rd_issue = 1'b0;
        csb_d    = 1'b1;
        web_d    = 1'b1;
        oeb_d    = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_next)
            S_WRITE: begin issue = 1'b1; csb_d = 1'b0; web_d = 1'b0; busy_d = 1'b1; end
            S_READ:  begin issue = 1'b1; rd_issue = 1'b1; csb_d = 1'b0; oeb_d = 1'b0; busy_d = 1'b1; end
            S_DRAIN: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= '0;
            left_q  <= '0;
            drain_q <= '0;
            address <= '0;
            datain  <= '0;
            CSB     <= 1'b1;
            WEB     <= 1'b1;
            OEB     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            CSB  <= csb_d;
            WEB  <= web_d;
            OEB  <= oeb_d;
            busy <= busy_d;
            done <= done_d;
            if (issue) begin
                lfsr_q  <= step_next;
                address <= addr_next;
                left_q  <= (state == S_IDLE) ? count - CNT_W'(1) : left_q - CNT_W'(1);
            end
            if (!web_d) datain <= step_words;
            if (state_next == S_DRAIN)
                drain_q <= (state == S_DRAIN) ? drain_q - LAT_W'(1) : LAT_W'(READ_LAT - 1);
        end
    end

    // Expected words ride alongside the read request until dataout is valid.
    always_ff @(posedge clk) begin
        if (reset || abort_hit) pipe_vld <= '0;
        else                    pipe_vld <= {pipe_vld[READ_LAT-1:0], rd_issue};
    end

    always_ff @(posedge clk) begin
        if (rd_issue) begin
            pipe_addr[0] <= addr_next;
            pipe_exp[0]  <= step_words;
        end
        for (int i = 1; i <= READ_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    always_comb begin
        mism = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (pipe_exp[READ_LAT][b*DATA_W +: DATA_W] != dataout[b*DATA_W +: DATA_W])
                mism = mism + MIS_W'(1);
        end
        err_sum  = ACC_W'(err_cnt) + ACC_W'(mism);
        err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        cmp_en   = pipe_vld[READ_LAT] && !abort_hit;
    end

    always_ff @(posedge clk) begin
        if (reset || (start_ok && mode)) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            err_flag       <= 1'b0;
        end else if (cmp_en && (mism != '0)) begin
            err_cnt  <= err_next;
            err_flag <= 1'b1;
            if (err_cnt == '0) first_err_addr <= pipe_addr[READ_LAT];
        end
    end

endmodule

// File: tb/tb_lfsr_sram_sweep.sv
// Directed bench: table of sweeps against a behavioural 4-bank SRAM, plus
// hand sequences for reset mid-sweep and abort during drain.
module tb_lfsr_sram_sweep;

    localparam logic [97:0] TB_TAP = 98'h2_0000_0000_0000_0000_0000_0041;

    logic         clk = 1'b0;
    logic         reset, start, mode, abort;
    logic [97:0]  rg_out;
    logic [6:0]   base_addr;
    logic [7:0]   count;
    logic [255:0] dataout, datain;
    logic [6:0]   address, first_err_addr;
    logic         CSB, WEB, OEB, busy, done, err_flag;
    logic [15:0]  err_cnt;

    logic [63:0]  mem [4][128];
    logic         c_req;
    logic [1:0]   c_bank;
    logic [6:0]   c_addr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lfsr_sram_sweep dut (
        .clk            (clk),
        .reset          (reset),
        .rg_out         (rg_out),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .count          (count),
        .abort          (abort),
        .dataout        (dataout),
        .datain         (datain),
        .address        (address),
        .CSB            (CSB),
        .WEB            (WEB),
        .OEB            (OEB),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .err_flag       (err_flag)
    );

    // Behavioural SRAM, one-cycle read latency; c_req flips bit 5 of one word.
    always @(posedge clk) begin
        if (c_req) mem[c_bank][c_addr] <= mem[c_bank][c_addr] ^ 64'h20;
        else if (!CSB && !WEB)
            for (int b = 0; b < 4; b++) mem[b][address] <= datain[b*64 +: 64];
        if (!CSB && !OEB)
            for (int b = 0; b < 4; b++) dataout[b*64 +: 64] <= mem[b][address];
    end

    function automatic logic [97:0] ref_step(input logic [97:0] s);
        logic [97:0] r;
        r = {1'b0, s[97:1]};
        if (s[0]) r = r ^ TB_TAP;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic corrupt(input logic [1:0] bank, input logic [6:0] a);
        @(negedge clk);
        c_req = 1'b1; c_bank = bank; c_addr = a;
        @(negedge clk);
        c_req = 1'b0;
    endtask

    // Launches one sweep and checks every request cycle against the model.
    task automatic run_sweep(input string name, input logic md, input logic [97:0] seed,
                             input logic [6:0] base, input logic [7:0] cnt, input int glitch_at);
        logic [97:0]  s;
        logic [255:0] exp_bus;
        logic [6:0]   exp_addr;
        int n_req, n_busy, done_at, addr_bad, data_bad, exp_done, exp_busy;
        s = (seed == '0) ? 98'd1 : seed;
        n_req = 0; n_busy = 0; done_at = -1; addr_bad = 0; data_bad = 0;
        exp_bus = '0;
        @(negedge clk);
        start = 1'b1; mode = md; rg_out = seed; base_addr = base; count = cnt;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= int'(cnt) + 8; c++) begin
            if (!CSB) begin
                exp_addr = 7'(int'(base) + n_req);
                for (int b = 0; b < 4; b++) begin
                    s = ref_step(s);
                    exp_bus[b*64 +: 64] = s[63:0];
                end
                if (address !== exp_addr) addr_bad++;
                if (md == 1'b0) begin
                    if (WEB !== 1'b0 || OEB !== 1'b1 || datain !== exp_bus) data_bad++;
                end else if (WEB !== 1'b1 || OEB !== 1'b0) data_bad++;
                n_req++;
            end
            if (busy) n_busy++;
            if (glitch_at != 0 && c == glitch_at) begin
                start = 1'b1; mode = ~md; rg_out = 98'h1234; base_addr = 7'h55; count = 8'd2;
            end else start = 1'b0;
            if (done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        exp_done = (cnt == 0) ? 1 : (md ? int'(cnt) + 2 : int'(cnt) + 1);
        exp_busy = (cnt == 0) ? 0 : (md ? int'(cnt) + 1 : int'(cnt));
        check({name, ".done_at"}, 128'(done_at), 128'(exp_done));
        check({name, ".requests"}, 128'(n_req), 128'(cnt));
        check({name, ".addr_bad"}, 128'(addr_bad), 128'(0));
        check({name, ".strobe_data_bad"}, 128'(data_bad), 128'(0));
        check({name, ".busy_cycles"}, 128'(n_busy), 128'(exp_busy));
    endtask

    typedef struct {
        string       name;
        logic        md;
        logic [97:0] seed;
        logic [6:0]  base;
        logic [7:0]  cnt;
        int          glitch_at;
        int          c_bank;
        logic [6:0]  c_addr;
        logic [15:0] exp_err;
        logic [6:0]  exp_first;
        logic        exp_flag;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int done_seen;
        int csb_seen;
        vecs[0]  = '{"wr_seed1",     1'b0, 98'd1, 7'd0,   8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[1]  = '{"rd_clean",     1'b1, 98'd1, 7'd0,   8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[2]  = '{"rd_b1_a2",     1'b1, 98'd1, 7'd0,   8'd4, 0,  1, 7'd2, 16'd1, 7'd2, 1'b1};
        vecs[3]  = '{"rd_b3_a3",     1'b1, 98'd1, 7'd0,   8'd4, 0,  3, 7'd3, 16'd2, 7'd2, 1'b1};
        vecs[4]  = '{"wr_wrap",      1'b0, 98'd5, 7'd126, 8'd4, 0, -1, 7'd0, 16'd2, 7'd2, 1'b1};
        vecs[5]  = '{"rd_cnt0",      1'b1, 98'd5, 7'd50,  8'd0, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[6]  = '{"rd_wrap",      1'b1, 98'd5, 7'd126, 8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[7]  = '{"wr_cnt0",      1'b0, 98'd1, 7'd9,   8'd0, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[8]  = '{"wr_seed0",     1'b0, 98'd0, 7'd0,   8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[9]  = '{"rd_seed1",     1'b1, 98'd1, 7'd0,   8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[10] = '{"wr_busy_strt", 1'b0, 98'd9, 7'd40,  8'd4, 2, -1, 7'd0, 16'd0, 7'd0, 1'b0};
        vecs[11] = '{"rd_busy_strt", 1'b1, 98'd9, 7'd40,  8'd4, 0, -1, 7'd0, 16'd0, 7'd0, 1'b0};

        reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; rg_out = '0;
        base_addr = '0; count = '0; c_req = 1'b0; c_bank = '0; c_addr = '0;

        repeat (2) @(negedge clk);
        check("rst.strobes", 128'({CSB, WEB, OEB}), 128'(3'b111));
        check("rst.busy_done", 128'({busy, done}), 128'(2'b00));
        check("rst.address", 128'(address), 128'(0));
        check("rst.err", 128'({err_cnt, first_err_addr, err_flag}), 128'(0));
        reset = 1'b0;

        // Reset lands while the third write (k=2) is on the bus.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; rg_out = 98'd3; base_addr = 7'd10; count = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.k2_addr", 128'({WEB, address}), 128'({1'b0, 7'd12}));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.idle", 128'({CSB, WEB, OEB, busy, done}), 128'(5'b11100));
        done_seen = 0; csb_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
            if (!CSB) csb_seen++;
        end
        check("midrst.no_done", 128'(done_seen), 128'(0));
        check("midrst.no_access", 128'(csb_seen), 128'(0));

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].c_bank >= 0) corrupt(2'(vecs[i].c_bank), vecs[i].c_addr);
            run_sweep(vecs[i].name, vecs[i].md, vecs[i].seed, vecs[i].base, vecs[i].cnt,
                      vecs[i].glitch_at);
            check({vecs[i].name, ".err_cnt"}, 128'(err_cnt), 128'(vecs[i].exp_err));
            check({vecs[i].name, ".first_err"}, 128'(first_err_addr), 128'(vecs[i].exp_first));
            check({vecs[i].name, ".err_flag"}, 128'(err_flag), 128'(vecs[i].exp_flag));
        end

        // Address 0 was last written from seed 0, which must behave as seed 1.
        check("mem.a0_b0", 128'(mem[0][0]), 128'(64'h41));
        check("mem.a0_b1", 128'(mem[1][0]), 128'(64'h61));
        check("mem.a0_b2", 128'(mem[2][0]), 128'(64'h71));
        check("mem.a0_b3", 128'(mem[3][0]), 128'(64'h79));

        // Abort in DRAIN discards the compare of the last (corrupted) word.
        run_sweep("ab_wr", 1'b0, 98'd7, 7'd20, 8'd2, 0);
        corrupt(2'd2, 7'd20);
        corrupt(2'd0, 7'd21);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; rg_out = 98'd7; base_addr = 7'd20; count = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("ab.in_drain", 128'({CSB, OEB, busy}), 128'(3'b111));
        check("ab.err_before", 128'({err_cnt, first_err_addr}), 128'({16'd1, 7'd20}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab.idle", 128'({CSB, busy, done}), 128'(3'b100));
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("ab.no_done", 128'(done_seen), 128'(0));
        check("ab.err_after", 128'({err_cnt, first_err_addr, err_flag}),
              128'({16'd1, 7'd20, 1'b1}));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
